// File: rtl/alu_result_skid.sv
`default_nettype none
// ============================================================================
// alu_result_skid : registered valid/ready output stage for the bitwise logic
// unit, 2-entry skid buffer with capture-time zero/parity/MSB flags.
// Revision: 1.0
// ============================================================================
module alu_result_skid #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int CNTW  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OPW-1:0]   out_op,
    output logic             out_zero,
    output logic             out_parity,
    output logic             out_neg,
    output logic [CNTW-1:0]  xfer_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t state;
    state_t next_state;

    logic             in_fire;
    logic             out_fire;
    logic             load_head_in;
    logic             load_head_skid;
    logic             load_skid;

    logic             cap_zero;
    logic             cap_parity;
    logic             cap_neg;

    logic [WIDTH-1:0] skid_data;
    logic [OPW-1:0]   skid_op;
    logic             skid_zero;
    logic             skid_parity;
    logic             skid_neg;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Flags are derived once at capture and travel with the entry.
    assign cap_zero   = ~|in_data;
    assign cap_parity = ^in_data;
    assign cap_neg    = in_data[WIDTH-1];

    always_comb begin
        next_state     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_head_in = 1'b1;
                    next_state   = ONE;
                end
            end
            ONE: begin
                case ({in_fire, out_fire})
                    2'b11: begin
                        load_head_in = 1'b1;
                    end
                    2'b10: begin
                        load_skid  = 1'b1;
                        next_state = FULL;
                    end
                    2'b01: begin
                        next_state = EMPTY;
                    end
                    default: begin
                        next_state = ONE;
                    end
                endcase
            end
            FULL: begin
                // in_ready is low here, so only the drain path is possible.
                if (out_fire) begin
                    load_head_skid = 1'b1;
                    next_state     = ONE;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= next_state;
            out_valid <= (next_state != EMPTY);
            in_ready  <= (next_state != FULL);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data   <= '0;
            out_op     <= '0;
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
            out_neg    <= 1'b0;
        end else if (load_head_in) begin
            out_data   <= in_data;
            out_op     <= in_op;
            out_zero   <= cap_zero;
            out_parity <= cap_parity;
            out_neg    <= cap_neg;
        end else if (load_head_skid) begin
            out_data   <= skid_data;
            out_op     <= skid_op;
            out_zero   <= skid_zero;
            out_parity <= skid_parity;
            out_neg    <= skid_neg;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            skid_data   <= '0;
            skid_op     <= '0;
            skid_zero   <= 1'b0;
            skid_parity <= 1'b0;
            skid_neg    <= 1'b0;
        end else if (load_skid) begin
            skid_data   <= in_data;
            skid_op     <= in_op;
            skid_zero   <= cap_zero;
            skid_parity <= cap_parity;
            skid_neg    <= cap_neg;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xfer_count <= '0;
        end else if (out_fire) begin
            xfer_count <= xfer_count + CNTW'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_skid.sv
`default_nettype none
// ============================================================================
// tb_alu_result_skid : directed stimulus with a queue scoreboard and an
// independent output monitor for alu_result_skid.
// Revision: 1.0
// ============================================================================
module tb_alu_result_skid;

    localparam int WIDTH = 32;
    localparam int OPW   = 5;
    localparam int CNTW  = 16;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [OPW-1:0]   in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OPW-1:0]   out_op;
    logic             out_zero;
    logic             out_parity;
    logic             out_neg;
    logic [CNTW-1:0]  xfer_count;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [OPW-1:0]   op;
    } entry_t;

    entry_t sb[$];
    int     tests  = 0;
    int     errors = 0;
    bit     stall_seen = 0;

    alu_result_skid #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .out_neg    (out_neg),
        .xfer_count (xfer_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Holds in_valid until accepted; an accepted entry is pushed as expected output.
    task automatic send(input logic [WIDTH-1:0] d, input logic [OPW-1:0] op);
        int  waited = 0;
        bit  done   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        while (!done) begin
            @(negedge clock);
            if (in_ready) begin
                sb.push_back('{data: d, op: op});
                done = 1;
            end else begin
                waited++;
                stall_seen = 1;
                if (waited > 200) begin
                    check("send_timeout", 64'(waited), 64'd0);
                    done = 1;
                end
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output fire and checks stall stability.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] held_data;
    logic [OPW-1:0]   held_op;
    always @(negedge clock) begin
        entry_t e;
        if (reset_n && out_valid && prev_stall) begin
            check("stall_data_stable", 64'(out_data), 64'(held_data));
            check("stall_op_stable", 64'(out_op), 64'(held_op));
        end
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(out_data), 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_op", 64'(out_op), 64'(e.op));
                check("out_zero", 64'(out_zero), 64'(e.data == '0));
                check("out_parity", 64'(out_parity), 64'(^e.data));
                check("out_neg", 64'(out_neg), 64'(e.data[WIDTH-1]));
            end
        end
        prev_stall = reset_n && out_valid && !out_ready;
        held_data  = out_data;
        held_op    = out_op;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = '0;
        out_ready = 1'b0;

        // Reset values while held in reset
        cycles(2);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_flags", 64'({out_zero, out_parity, out_neg}), 64'd0);
        check("rst_xfer_count", 64'(xfer_count), 64'd0);
        reset_n = 1'b1;

        // Fill to FULL, then assert reset mid-cycle: both entries discarded
        send(32'h1111_1111, 5'd1);
        send(32'h2222_2222, 5'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_data", 64'(out_data), 64'h1111_1111);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_out_data", 64'(out_data), 64'd0);
        check("async_rst_xfer_count", 64'(xfer_count), 64'd0);
        sb.delete();
        cycles(1);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_rst_empty", 64'(out_valid), 64'd0);
        end
        cycles(1);

        // Single transfer with hand-computed flags
        send(32'hFFFF_0000, 5'b00011);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'hFFFF_0000);
        check("single_zpn", 64'({out_zero, out_parity, out_neg}), 64'b001);
        cycles(1);
        check("single_empty", 64'(out_valid), 64'd0);
        check("single_count", 64'(xfer_count), 64'd1);

        // Zero and parity flags
        send(32'h0000_0000, 5'd4);
        check("zero_zpn", 64'({out_zero, out_parity, out_neg}), 64'b100);
        send(32'h0000_0001, 5'd5);
        check("one_zpn", 64'({out_zero, out_parity, out_neg}), 64'b010);
        cycles(2);
        check("flags_count", 64'(xfer_count), 64'd3);

        // Backpressure: A, B accepted, C blocked; junk while blocked has no effect
        out_ready = 1'b0;
        send(32'hA, 5'd10);
        send(32'hB, 5'd11);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hDEAD_0000 + 32'(i);
            in_op   = 5'd31;
            @(negedge clock);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
            check("bp_hold_head", 64'(out_data), 64'hA);
            cycles(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(32'hC, 5'd12);
        cycles(3);
        check("bp_count", 64'(xfer_count), 64'd6);
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Streaming at full throughput
        stall_seen = 0;
        for (int i = 1; i <= 20; i++) send(32'(i), 5'(i));
        check("stream_no_stall", 64'(stall_seen), 64'd0);
        cycles(1);
        check("stream_count", 64'(xfer_count), 64'd26);
        check("stream_empty", 64'(out_valid), 64'd0);

        // Counter wrap after 65536 fires from reset
        reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
        for (int i = 1; i <= 65536; i++) send(32'(i) ^ 32'h8000_0000, 5'(i));
        check("wrap_pre_count", 64'(xfer_count), 64'hFFFF);
        check("wrap_last_data", 64'(out_data), 64'h8001_0000);
        cycles(1);
        check("wrap_count", 64'(xfer_count), 64'h0000);
        check("wrap_empty", 64'(out_valid), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
